// File: rtl/cmn_lfsr_pkg.sv
// cmn_lfsr_pkg: primitive tap masks and weighted-output bit ranges
// shared by the cmn_lfsr_gen LFSR family.
package cmn_lfsr_pkg;

    localparam logic [3:0]  LFSR_TAPS_4  = 4'b1001;
    localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
    localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

    localparam int LFSR_W0_BIT    = 0;
    localparam int LFSR_W1_LO     = 1;
    localparam int LFSR_W1_HI     = 2;
    localparam int LFSR_W2_LO     = 3;
    localparam int LFSR_W2_HI     = 5;
    localparam int LFSR_W3_LO     = 6;
    localparam int LFSR_W3_HI     = 9;
    localparam int LFSR_W_MIN_WID = LFSR_W3_HI + 1;

    // AND-reductions of wider groups give ~1/2, 1/4, 1/8, 1/16 densities
    function automatic logic [3:0] lfsr_weight(input logic [63:0] s);
        logic [3:0] w;
        w[0] = s[LFSR_W0_BIT];
        w[1] = &s[LFSR_W1_HI:LFSR_W1_LO];
        w[2] = &s[LFSR_W2_HI:LFSR_W2_LO];
        w[3] = &s[LFSR_W3_HI:LFSR_W3_LO];
        return w;
    endfunction

endpackage

// File: rtl/cmn_lfsr_step.sv
// cmn_lfsr_step: one combinational Fibonacci shift,
// feedback is the XOR of the tapped state bits shifted in at bit 0.
module cmn_lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic [WIDTH-1:0] i_s,
    output logic [WIDTH-1:0] o_s
);

    logic w_fb;

    assign w_fb = ^(i_s & TAPS);
    assign o_s  = {i_s[WIDTH-2:0], w_fb};

endmodule

// File: rtl/cmn_lfsr_gen.sv
// cmn_lfsr_gen: parametrised Fibonacci LFSR advancing STEP shifts per cycle.
// Define CMN_LFSR_WEIGHTED_EN to add the weighted out_w port.
module cmn_lfsr_gen
    import cmn_lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             lockup
`ifdef CMN_LFSR_WEIGHTED_EN
    ,
    output logic [3:0]       out_w
`endif
);

    logic [WIDTH-1:0] r_state;
    logic             r_wrap;
    logic             r_lock;
    logic [STEP-1:0]  w_hit;
    logic [WIDTH-1:0] w_next;

    if (WIDTH < 3 || WIDTH > 64) begin : g_chk_width
        $error("cmn_lfsr_gen: WIDTH must be 3..64");
    end
    if (SEED == '0) begin : g_chk_seed
        $error("cmn_lfsr_gen: SEED must be non-zero");
    end
    if (STEP < 1 || STEP > WIDTH) begin : g_chk_step
        $error("cmn_lfsr_gen: STEP must be 1..WIDTH");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_chk_taps
        $error("cmn_lfsr_gen: TAPS[WIDTH-1] must be set");
    end

    // Each stage flags if its result lands on SEED, so skipped states still wrap
    for (genvar gi = 0; gi < STEP; gi++) begin : g_step
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;
        if (gi == 0) begin : g_first
            assign w_in = r_state;
        end else begin : g_rest
            assign w_in = g_step[gi-1].w_out;
        end
        cmn_lfsr_step #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_step (
            .i_s (w_in),
            .o_s (w_out)
        );
        assign w_hit[gi] = (w_out == SEED);
    end

    assign w_next = g_step[STEP-1].w_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED;
            r_wrap  <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_lock <= 1'b0;
            if (load) begin
                if (seed_in != '0) begin
                    r_state <= seed_in;
                end else begin
                    r_state <= SEED;
                    r_lock  <= 1'b1;
                end
            end else if (en) begin
                if (r_state == '0) begin
                    r_state <= SEED;
                    r_lock  <= 1'b1;
                end else begin
                    r_state <= w_next;
                    r_wrap  <= |w_hit;
                end
            end
        end
    end

    assign out    = r_state;
    assign wrap   = r_wrap;
    assign lockup = r_lock;

`ifdef CMN_LFSR_WEIGHTED_EN
    if (WIDTH < LFSR_W_MIN_WID) begin : g_chk_wwidth
        $error("cmn_lfsr_gen: weighted outputs need WIDTH >= 10");
    end
    assign out_w = lfsr_weight(64'(r_state));
`endif

endmodule

// File: tb/tb_cmn_lfsr_gen.sv
// tb_cmn_lfsr_gen: directed checks on 4-bit instances plus a
// period-table model checked every cycle on an 8-bit STEP=5 instance.
module tb_cmn_lfsr_gen;
    import cmn_lfsr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4_n, en4, load4, wrap4, lock4;
    logic [3:0] seed4, out4;
    logic       rst3_n, en3, load3, wrap3, lock3;
    logic [3:0] seed3, out3;
    logic       rst8_n, en8, load8, wrap8, lock8;
    logic [7:0] seed8, out8;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    cmn_lfsr_gen #(.WIDTH(4), .TAPS(LFSR_TAPS_4), .SEED(4'h1), .STEP(1)) dut4 (
        .clk(clk), .rst_n(rst4_n), .en(en4), .load(load4), .seed_in(seed4),
        .out(out4), .wrap(wrap4), .lockup(lock4));

    cmn_lfsr_gen #(.WIDTH(4), .TAPS(LFSR_TAPS_4), .SEED(4'h1), .STEP(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .en(en3), .load(load3), .seed_in(seed3),
        .out(out3), .wrap(wrap3), .lockup(lock3));

    cmn_lfsr_gen #(.WIDTH(8), .TAPS(LFSR_TAPS_8), .SEED(8'h01), .STEP(5)) dut8 (
        .clk(clk), .rst_n(rst8_n), .en(en8), .load(load8), .seed_in(seed8),
        .out(out8), .wrap(wrap8), .lockup(lock8));

    // Model: the full period as a table, state tracked as a position in it
    logic [7:0] m_seq [255];
    int         m_idx [256];
    int         m_pos;
    bit         m_wrap, m_lock, m_ready;

    function automatic logic [7:0] nxt8(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS_8)};
    endfunction

    always @(posedge clk or negedge rst8_n) begin
        if (!rst8_n) begin
            m_pos = 0; m_wrap = 0; m_lock = 0;
        end else begin
            m_wrap = 0; m_lock = 0;
            if (load8) begin
                if (seed8 == 8'h00) begin
                    m_pos = 0; m_lock = 1;
                end else begin
                    m_pos = m_idx[seed8];
                end
            end else if (en8) begin
                m_wrap = (m_pos + 5 >= 255);
                m_pos  = (m_pos + 5) % 255;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready && rst8_n) begin
            chk("d8_out", out8, m_seq[m_pos]);
            chk("d8_wrap", wrap8, m_wrap);
            chk("d8_lockup", lock8, m_lock);
        end
    end

    logic [3:0] t4 [16];
    logic [3:0] t3 [6];

    initial begin
        logic [7:0] s;
        int nd;
        rst4_n = 0; rst3_n = 0; rst8_n = 0;
        en4 = 0; load4 = 0; seed4 = 0;
        en3 = 0; load3 = 0; seed3 = 0;
        en8 = 0; load8 = 0; seed8 = 0;
        t4 = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
               4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
        t3 = '{4'h1, 4'hF, 4'hA, 4'h6, 4'h2, 4'h1};

        for (int v = 0; v < 256; v++) m_idx[v] = -1;
        s = 8'h01;
        for (int i = 0; i < 255; i++) begin
            m_seq[i] = s;
            m_idx[s] = i;
            s = nxt8(s);
        end
        nd = 0;
        for (int v = 1; v < 256; v++) if (m_idx[v] >= 0) nd++;
        chk("model_period", nd, 255);
        chk("model_seq1", m_seq[1], 8'h02);
        chk("model_seq4", m_seq[4], 8'h11);
        m_ready = 1;

        @(negedge clk);
        chk("rst_out4", out4, 4'h1);
        chk("rst_wrap4", wrap4, 1'b0);
        chk("rst_lock4", lock4, 1'b0);
        chk("rst_out3", out3, 4'h1);
        rst4_n = 1; rst3_n = 1; rst8_n = 1;
        en4 = 1; en3 = 1;

        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            chk("seq4_out", out4, t4[k]);
            chk("seq4_wrap", wrap4, k == 15);
            if (k <= 5) begin
                chk("seq3_out", out3, t3[k]);
                chk("seq3_wrap", wrap3, k == 5);
            end
            if (k == 5) begin
                en3 = 0;
                #2 rst3_n = 0;
                #1;
                chk("async3_out", out3, 4'h1);
                chk("async3_wrap", wrap3, 1'b0);
            end
            if (k == 6) rst3_n = 1;
        end

        en4 = 0;
        @(negedge clk);
        chk("hold_out", out4, 4'h1);
        chk("hold_wrap", wrap4, 1'b0);

        load4 = 1; en4 = 1; seed4 = 4'hA;
        @(negedge clk);
        chk("load_out", out4, 4'hA);
        chk("load_wrap", wrap4, 1'b0);
        chk("load_lock", lock4, 1'b0);
        load4 = 0;
        @(negedge clk);
        chk("after_load", out4, 4'h5);

        en4 = 0; load4 = 1; seed4 = 4'h0;
        @(negedge clk);
        chk("load0_out", out4, 4'h1);
        chk("load0_lock", lock4, 1'b1);
        load4 = 0;
        @(negedge clk);
        chk("load0_lock_clr", lock4, 1'b0);
        chk("load0_hold", out4, 4'h1);

        force dut4.r_state = 4'h0;
        #1 release dut4.r_state;
        en4 = 1;
        @(negedge clk);
        chk("zero_out", out4, 4'h1);
        chk("zero_lock", lock4, 1'b1);
        chk("zero_wrap", wrap4, 1'b0);
        @(negedge clk);
        chk("zero_next", out4, 4'h3);
        chk("zero_lock_clr", lock4, 1'b0);
        @(negedge clk);
        chk("zero_next2", out4, 4'h7);
        #2 rst4_n = 0;
        #1;
        chk("async4_out", out4, 4'h1);
        chk("async4_wrap", wrap4, 1'b0);
        chk("async4_lock", lock4, 1'b0);
        en4 = 0;
        @(negedge clk);
        rst4_n = 1;
        @(negedge clk);
        chk("post_rst4", out4, 4'h1);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load8 = (i == 37) || (i == 150) || (i == 260);
            seed8 = (i == 150) ? 8'h00 : ((i == 37) ? 8'h3C : 8'hFF);
            en8   = (i % 7) != 3;
        end
        @(negedge clk);
        en8 = 0; load8 = 0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
